// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the memory bus controller: FSM encoding,
// pipeline stall vectors and the data value returned on an aborted access.
package mem_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DACC = 2'd1,
    ST_IACC = 2'd2
  } bus_state_t;

  localparam logic [4:0]  STALL_DATA  = 5'b11111;
  localparam logic [4:0]  STALL_FETCH = 5'b00011;
  localparam logic [4:0]  STALL_NONE  = 5'b00000;
  localparam logic [31:0] ZERO_DATA   = 32'h0000_0000;
  localparam logic [3:0]  SEL_WORD    = 4'b1111;

endpackage

// File: rtl/mem_bus_ctrl.sv
// Arbitrates instruction fetch and load/store traffic onto one shared memory
// bus, with data priority, a bus timeout and pipeline stall/flush generation.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [4:0]  stall,
  output logic        flush_id,
  output logic        bus_err
);

  localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

  bus_state_t state_r;
  bus_state_t state_next_s;
  logic [3:0] count_r;
  logic       grant_ok_s;
  logic       grant_data_s;
  logic       grant_fetch_s;
  logic       timeout_s;

  // A ready pulse blocks a new grant so the still-held request is not re-served.
  assign grant_ok_s    = (state_r == ST_IDLE) && !if_ready && !mem_ready;
  assign grant_data_s  = grant_ok_s && mem_req;
  assign grant_fetch_s = grant_ok_s && !mem_req && if_req;
  // Counter holds the 1-based cycle number of the current bus access.
  assign timeout_s     = (count_r == TIMEOUT_CNT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: ack wins over timeout
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_data_s) begin
          state_next_s = ST_DACC;
        end else if (grant_fetch_s) begin
          state_next_s = ST_IACC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_DACC, ST_IACC: begin
        if (bus_ack || timeout_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = state_r;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output logic: bus request from state, stall/flush from live requests
  always_comb begin
    bus_req  = (state_r != ST_IDLE);
    stall    = STALL_NONE;
    flush_id = 1'b0;
    if (rst) begin
      stall    = STALL_NONE;
      flush_id = 1'b0;
    end else if (mem_req && !mem_ready) begin
      stall    = STALL_DATA;
      flush_id = 1'b0;
    end else if (if_req && !if_ready) begin
      stall    = STALL_FETCH;
      flush_id = 1'b1;
    end else begin
      stall    = STALL_NONE;
      flush_id = 1'b0;
    end
  end

  // Bus command capture, cycle counter and completion/abort responses
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r   <= 4'd0;
      bus_we    <= 1'b0;
      bus_sel   <= 4'b0000;
      bus_addr  <= ZERO_DATA;
      bus_wdata <= ZERO_DATA;
      if_rdata  <= ZERO_DATA;
      mem_rdata <= ZERO_DATA;
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      bus_err   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_data_s) begin
            count_r   <= 4'd1;
            bus_we    <= mem_we;
            bus_sel   <= mem_sel;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
          end else if (grant_fetch_s) begin
            count_r   <= 4'd1;
            bus_we    <= 1'b0;
            bus_sel   <= SEL_WORD;
            bus_addr  <= if_addr;
            bus_wdata <= ZERO_DATA;
          end else begin
            count_r <= 4'd0;
          end
        end
        ST_DACC: begin
          if (bus_ack) begin
            mem_rdata <= bus_rdata;
            mem_ready <= 1'b1;
          end else if (timeout_s) begin
            mem_rdata <= ZERO_DATA;
            mem_ready <= 1'b1;
            bus_err   <= 1'b1;
          end else begin
            count_r <= count_r + 4'd1;
          end
        end
        ST_IACC: begin
          if (bus_ack) begin
            if_rdata <= bus_rdata;
            if_ready <= 1'b1;
          end else if (timeout_s) begin
            if_rdata <= ZERO_DATA;
            if_ready <= 1'b1;
            bus_err  <= 1'b1;
          end else begin
            count_r <= count_r + 4'd1;
          end
        end
        default: begin
          count_r <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Randomized scoreboard bench for mem_bus_ctrl: a memory responder whose
// latency and data are functions of the address lets outcomes be predicted at issue.
module tb_mem_bus_ctrl;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [4:0]  stall;
  logic        flush_id;
  logic        bus_err;

  mem_bus_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .stall(stall), .flush_id(flush_id), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t mem_q[$];
  exp_t if_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic stray_force = 1'b0;

  // Memory model: ack arrives on bus cycle lat_of(addr); beyond TO it never does.
  function automatic int lat_of(input logic [31:0] a);
    return (int'(a[4:0]) % 18) + 1;
  endfunction

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
  endfunction

  function automatic exp_t predict(input logic [31:0] a);
    exp_t e;
    e.err   = (lat_of(a) > TO);
    e.rdata = e.err ? 32'h0 : data_of(a);
    return e;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus responder
  initial begin
    int cyc = 0;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (bus_req === 1'b1) begin
        cyc++;
        if (cyc == lat_of(bus_addr)) begin
          bus_ack   = 1'b1;
          bus_rdata = data_of(bus_addr);
        end else begin
          bus_ack   = 1'b0;
          bus_rdata = $urandom;
        end
      end else begin
        cyc       = 0;
        bus_ack   = stray_force || ($urandom_range(0, 7) == 0);
        bus_rdata = $urandom;
      end
    end
  end

  // Monitor: scoreboard pops, grant source, command hold and stall checks
  initial begin
    logic        prev_req = 1'b0;
    logic [68:0] held;
    logic [4:0]  exp_stall;
    logic        exp_flush;
    exp_t        e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        exp_stall = 5'b00000; exp_flush = 1'b0;
      end else if (mem_req && !mem_ready) begin
        exp_stall = 5'b11111; exp_flush = 1'b0;
      end else if (if_req && !if_ready) begin
        exp_stall = 5'b00011; exp_flush = 1'b1;
      end else begin
        exp_stall = 5'b00000; exp_flush = 1'b0;
      end
      check("stall_flush", {stall, flush_id}, {exp_stall, exp_flush});

      if (mem_ready) begin
        check("mem_ready_expected", mem_q.size() != 0, 1'b1);
        if (mem_q.size() != 0) begin
          e = mem_q.pop_front();
          check("mem_response", {mem_rdata, bus_err}, {e.rdata, e.err});
        end
      end
      if (if_ready) begin
        check("if_ready_expected", if_q.size() != 0, 1'b1);
        if (if_q.size() != 0) begin
          e = if_q.pop_front();
          check("if_response", {if_rdata, bus_err}, {e.rdata, e.err});
        end
      end
      check("err_only_with_ready", bus_err & ~(mem_ready | if_ready), 1'b0);

      if (bus_req && !prev_req) begin
        check("grant_has_request", if_req | mem_req, 1'b1);
        if (mem_req) begin
          check("grant_data_cmd", {bus_we, bus_sel, bus_addr, bus_wdata},
                {mem_we, mem_sel, mem_addr, mem_wdata});
        end else if (if_req) begin
          check("grant_fetch_cmd", {bus_we, bus_addr}, {1'b0, if_addr});
        end
        held = {bus_we, bus_sel, bus_addr, bus_wdata};
      end else if (bus_req && prev_req) begin
        check("bus_cmd_hold", {bus_we, bus_sel, bus_addr, bus_wdata}, held);
      end
      prev_req = bus_req;
    end
  end

  task automatic retire_on_ready();
    if (mem_req && mem_ready) mem_req = 1'b0;
    if (if_req && if_ready) if_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h0;
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_bus", {bus_req, bus_we, bus_sel, bus_addr, bus_wdata}, 70'h0);
    check("reset_data", {if_rdata, mem_rdata, if_ready, mem_ready, bus_err}, 67'h0);
    check("reset_stall", {stall, flush_id}, 6'h0);
    @(negedge clk);
    if_req = 1'b0; mem_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Random traffic: requests held until their ready pulse
    repeat (4000) begin
      @(negedge clk);
      retire_on_ready();
      if (!mem_req && $urandom_range(0, 3) == 0) begin
        mem_addr  = $urandom;
        mem_we    = 1'($urandom_range(0, 1));
        mem_sel   = 4'($urandom_range(0, 15));
        mem_wdata = $urandom;
        mem_req   = 1'b1;
        mem_q.push_back(predict(mem_addr));
      end
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_addr = $urandom;
        if_req  = 1'b1;
        if_q.push_back(predict(if_addr));
      end
    end

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      retire_on_ready();
      if (!mem_req && !if_req && mem_q.size() == 0 && if_q.size() == 0) break;
    end
    check("drain_mem_q", mem_q.size(), 0);
    check("drain_if_q", if_q.size(), 0);

    // Reset in the middle of a fetch, then stray acks must be ignored
    @(negedge clk);
    if_addr = 32'h0000_2010;
    if_req  = 1'b1;
    repeat (3) @(negedge clk);
    check("fetch_in_progress", bus_req, 1'b1);
    rst = 1'b1;
    if_req = 1'b0;
    stray_force = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_bus", {bus_req, bus_we, bus_sel, bus_addr, bus_wdata}, 70'h0);
    check("midrst_data", {if_rdata, mem_rdata, if_ready, mem_ready, bus_err}, 67'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      check("post_rst_quiet", {bus_req, if_ready, mem_ready, bus_err}, 4'h0);
    end
    @(negedge clk);
    stray_force = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
